tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Four-channel time-division demultiplexer. It is the receive end of a 4:1 selected-line link.
- It takes a serialised beat stream, where slot 0 is marked by a frame-sync flag, and steers each beat into one of four registered channel outputs.
- Each captured beat raises a per-channel valid pulse. A frame-complete pulse follows slot 3.
- Includes a slot counter, sync tracking and error flagging. It sits between the link line and per-channel consumers.

Parameters:
- WIDTH, 8, bit width of one beat and of each channel register.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  beat present on in_data this cycle.
- in_data  input  WIDTH  beat payload.
- in_sync  input  1  qualifies a beat as slot 0 of a frame; ignored when in_valid=0.
- out_bus  output  4*WIDTH  channel registers; ch k = out_bus[k*WIDTH +: WIDTH].
- out_valid  output  4  one-cycle pulse on bit k when ch k is updated.
- frame_done  output  1  one-cycle pulse after a slot-3 capture.
- sync_err  output  1  one-cycle pulse on a sync violation.
- slot  output  2  slot index expected for the next valid beat.
- locked  output  1  high in RUN state.

Behaviour:
- Single clock. Reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block.
- Reset values: out_bus=0, out_valid=0, frame_done=0, sync_err=0, slot=0, locked=0, state=IDLE.
- Latency: beat accepted at edge N; out_bus and out_valid visible after edge N (1 cycle).
- Channel registers hold their value until rewritten. Reset is the only clear.
- Cycles with in_valid=0: no state change, all pulses low, slot holds.
- IDLE state:
  - valid beat with in_sync=0 is discarded silently (no sync_err).
  - valid beat with in_sync=1 is captured to ch0, out_valid[0] pulses, slot<=1, goes to RUN.
- RUN state, valid beat, expected slot s:
  - s=0, in_sync=1: capture ch0, slot<=1.
  - s=0, in_sync=0: missed sync. Beat dropped, sync_err pulses, slot<=0, goes to IDLE.
  - s in 1..3, in_sync=0: capture ch s, slot<=s+1. Slot 3 wraps slot to 0.
  - s in 1..3, in_sync=1: early sync. sync_err pulses, beat captured to ch0, out_valid[0] pulses, slot<=1, stays RUN. The partial frame gives no frame_done.
- frame_done pulses in the same cycle as out_valid[3], i.e. after the edge that captures slot 3.
- Only one out_valid bit is high in any cycle. sync_err and out_valid[0] may coincide (early sync).
- Reset mid-frame: everything returns to reset values on that edge. A beat presented in the reset cycle is ignored.
- slot reflects the counter directly. In IDLE, slot=0.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - adds input in_parity (1 bit) carrying even parity over in_data, and output parity_err (1 bit, reset 0).
  - A valid beat with bad parity is not written: its out_valid bit stays low and parity_err pulses. Slot still advances and the sync rules apply unchanged.
  - frame_done still pulses on slot 3 even if that beat was bad.
- Undefined: no in_parity or parity_err ports, and no checking.

Test Plan:
- Reset and clean frame: rst_n low 2 cycles, then beats A0(sync),B1,C2,D3 back-to-back.
  - out_valid = 0001, 0010, 0100, 1000 on successive cycles.
  - out_bus = 0xD3C2B1A0; frame_done pulses with out_valid[3]; slot wraps to 0; locked=1.
- Pre-sync garbage: in IDLE, send 0x55 and 0x66 without sync, then 0x11 with sync.
  - First two beats give no out_valid and no sync_err; 0x11 lands in ch0 and locked rises.
- Gaps: frame 0x01(sync),idle,idle,0x02,idle,0x03,0x04.
  - Captures occur only on valid cycles; out_bus = 0x04030201; one frame_done.
- Early sync: 0x10(sync),0x20,0x30(sync).
  - sync_err pulses on the third beat; ch0=0x30, ch1=0x20; slot=1; no frame_done.
- Missed sync: full frame, then 0x77 with in_sync=0 at slot 0.
  - sync_err pulses, beat dropped, locked=0, slot=0.
- Reset mid-frame: assert rst_n=0 after slot-1 capture.
  - Next edge: out_bus=0, slot=0, locked=0, all pulses 0.
  - With DEMUX_PARITY_EN, a bad-parity 0x03 at slot 2 gives parity_err=1 and ch2 unchanged.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// Link-side bundle for the 4-channel TDM demultiplexer.
// DEMUX_PARITY_EN adds in_parity / parity_err to the bundle.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_sync;
    logic [4*WIDTH-1:0]   out_bus;
    logic [3:0]           out_valid;
    logic                 frame_done;
    logic                 sync_err;
    logic [1:0]           slot;
    logic                 locked;
`ifdef DEMUX_PARITY_EN
    logic                 in_parity;
    logic                 parity_err;

    modport master (
        output in_valid, in_data, in_sync, in_parity,
        input  out_bus, out_valid, frame_done, sync_err, slot, locked, parity_err
    );
    modport slave (
        input  in_valid, in_data, in_sync, in_parity,
        output out_bus, out_valid, frame_done, sync_err, slot, locked, parity_err
    );
`else
    modport master (
        output in_valid, in_data, in_sync,
        input  out_bus, out_valid, frame_done, sync_err, slot, locked
    );
    modport slave (
        input  in_valid, in_data, in_sync,
        output out_bus, out_valid, frame_done, sync_err, slot, locked
    );
`endif
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: steers framed beats into registered channels.
// Optional even-parity checking on each beat is enabled by DEMUX_PARITY_EN.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_next;
    logic [1:0]       r_slot, w_slot_next;
    logic [3:0]       r_out_valid, w_out_valid_next;
    logic             r_frame_done, w_frame_done_next;
    logic             r_sync_err, w_sync_err_next;
    logic [WIDTH-1:0] r_ch [4];

    logic             w_capture;
    logic [1:0]       w_cap_ch;
    logic             w_parity_ok;
    logic             w_write;

`ifdef DEMUX_PARITY_EN
    logic             r_parity_err;

    assign w_parity_ok = ((^bus.in_data) == bus.in_parity);

    always_ff @(posedge clk) begin
        if (!rst_n) r_parity_err <= 1'b0;
        else        r_parity_err <= w_capture & ~w_parity_ok;
    end
    assign bus.parity_err = r_parity_err;
`else
    assign w_parity_ok = 1'b1;
`endif

    // A bad-parity beat still moves the slot/sync machinery; it just isn't written.
    assign w_write          = w_capture & w_parity_ok;
    assign w_out_valid_next = w_write ? (4'b0001 << w_cap_ch) : 4'b0000;

    always_comb begin
        w_state_next      = r_state;
        w_slot_next       = r_slot;
        w_capture         = 1'b0;
        w_cap_ch          = 2'd0;
        w_frame_done_next = 1'b0;
        w_sync_err_next   = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_sync) begin
                        w_capture    = 1'b1;
                        w_slot_next  = 2'd1;
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    if (r_slot == 2'd0) begin
                        if (bus.in_sync) begin
                            w_capture   = 1'b1;
                            w_slot_next = 2'd1;
                        end else begin
                            w_sync_err_next = 1'b1;
                            w_slot_next     = 2'd0;
                            w_state_next    = ST_IDLE;
                        end
                    end else if (!bus.in_sync) begin
                        w_capture         = 1'b1;
                        w_cap_ch          = r_slot;
                        w_slot_next       = r_slot + 2'd1;
                        w_frame_done_next = (r_slot == 2'd3);
                    end else begin
                        // Early sync: restart the frame on this beat as slot 0.
                        w_sync_err_next = 1'b1;
                        w_capture       = 1'b1;
                        w_slot_next     = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_slot       <= 2'd0;
            r_out_valid  <= 4'b0000;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_slot       <= w_slot_next;
            r_out_valid  <= w_out_valid_next;
            r_frame_done <= w_frame_done_next;
            r_sync_err   <= w_sync_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (!rst_n)
                    r_ch[gi] <= '0;
                else if (w_write && (w_cap_ch == 2'(gi)))
                    r_ch[gi] <= bus.in_data;
            end
            assign bus.out_bus[gi*WIDTH +: WIDTH] = r_ch[gi];
        end
    endgenerate

    assign bus.out_valid  = r_out_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;
    assign bus.slot       = r_slot;
    assign bus.locked     = (r_state == ST_RUN);
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 with hand-computed expectations.
// Parity checks are compiled in when DEMUX_PARITY_EN is defined.
module tb_tdm_demux4;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tdm_demux4_if #(.WIDTH(8)) bus ();

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One beat per clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic pbad);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
`ifdef DEMUX_PARITY_EN
        bus.in_parity = (^d) ^ pbad;
`endif
        @(posedge clk);
        #1;
        $display("beat rst_n=%0b v=%0b s=%0b d=%h bad_par=%0b -> bus=%h ov=%b fd=%0b se=%0b slot=%0d lk=%0b",
                 rst_n, v, s, d, pbad, bus.out_bus, bus.out_valid, bus.frame_done,
                 bus.sync_err, bus.slot, bus.locked);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = 8'h00;
`ifdef DEMUX_PARITY_EN
        bus.in_parity = 1'b0;
`endif

        // Reset state
        do_reset(2);
        check("rst_bus",   bus.out_bus, 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_fd",    32'(bus.frame_done), 32'h0);
        check("rst_serr",  32'(bus.sync_err), 32'h0);
        check("rst_slot",  32'(bus.slot), 32'h0);
        check("rst_lock",  32'(bus.locked), 32'h0);

        // Clean frame
        drive(1'b1, 1'b1, 8'hA0, 1'b0);
        check("cf0_valid", 32'(bus.out_valid), 32'h1);
        check("cf0_lock",  32'(bus.locked), 32'h1);
        check("cf0_slot",  32'(bus.slot), 32'h1);
        drive(1'b1, 1'b0, 8'hB1, 1'b0);
        check("cf1_valid", 32'(bus.out_valid), 32'h2);
        check("cf1_slot",  32'(bus.slot), 32'h2);
        drive(1'b1, 1'b0, 8'hC2, 1'b0);
        check("cf2_valid", 32'(bus.out_valid), 32'h4);
        check("cf2_fd",    32'(bus.frame_done), 32'h0);
        drive(1'b1, 1'b0, 8'hD3, 1'b0);
        check("cf3_valid", 32'(bus.out_valid), 32'h8);
        check("cf3_fd",    32'(bus.frame_done), 32'h1);
        check("cf3_slot",  32'(bus.slot), 32'h0);
        check("cf3_bus",   bus.out_bus, 32'hD3C2B1A0);
        check("cf3_lock",  32'(bus.locked), 32'h1);
        drive(1'b0, 1'b0, 8'hEE, 1'b0);
        check("cf_idle_valid", 32'(bus.out_valid), 32'h0);
        check("cf_idle_fd",    32'(bus.frame_done), 32'h0);
        check("cf_idle_bus",   bus.out_bus, 32'hD3C2B1A0);

        // Pre-sync garbage in IDLE
        do_reset(1);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        check("pg0_valid", 32'(bus.out_valid), 32'h0);
        check("pg0_serr",  32'(bus.sync_err), 32'h0);
        check("pg0_lock",  32'(bus.locked), 32'h0);
        drive(1'b1, 1'b0, 8'h66, 1'b0);
        check("pg1_valid", 32'(bus.out_valid), 32'h0);
        check("pg1_serr",  32'(bus.sync_err), 32'h0);
        drive(1'b1, 1'b1, 8'h11, 1'b0);
        check("pg2_valid", 32'(bus.out_valid), 32'h1);
        check("pg2_bus",   bus.out_bus, 32'h00000011);
        check("pg2_lock",  32'(bus.locked), 32'h1);

        // Gaps between beats
        do_reset(1);
        drive(1'b1, 1'b1, 8'h01, 1'b0);
        drive(1'b0, 1'b0, 8'hFF, 1'b0);
        check("gap_idle_valid", 32'(bus.out_valid), 32'h0);
        check("gap_idle_slot",  32'(bus.slot), 32'h1);
        drive(1'b0, 1'b1, 8'hFE, 1'b0);
        check("gap_idle2_bus",  bus.out_bus, 32'h00000001);
        drive(1'b1, 1'b0, 8'h02, 1'b0);
        check("gap1_valid", 32'(bus.out_valid), 32'h2);
        drive(1'b0, 1'b0, 8'hFD, 1'b0);
        drive(1'b1, 1'b0, 8'h03, 1'b0);
        check("gap2_fd",    32'(bus.frame_done), 32'h0);
        drive(1'b1, 1'b0, 8'h04, 1'b0);
        check("gap3_fd",    32'(bus.frame_done), 32'h1);
        check("gap3_bus",   bus.out_bus, 32'h04030201);

        // Early sync
        drive(1'b1, 1'b1, 8'h10, 1'b0);
        drive(1'b1, 1'b0, 8'h20, 1'b0);
        drive(1'b1, 1'b1, 8'h30, 1'b0);
        check("es_serr",  32'(bus.sync_err), 32'h1);
        check("es_valid", 32'(bus.out_valid), 32'h1);
        check("es_slot",  32'(bus.slot), 32'h1);
        check("es_fd",    32'(bus.frame_done), 32'h0);
        check("es_bus",   bus.out_bus, 32'h04032030);
        check("es_lock",  32'(bus.locked), 32'h1);

        // Complete the frame, then miss the sync
        drive(1'b1, 1'b0, 8'hA1, 1'b0);
        drive(1'b1, 1'b0, 8'hA2, 1'b0);
        drive(1'b1, 1'b0, 8'hA3, 1'b0);
        check("ms_pre_fd",  32'(bus.frame_done), 32'h1);
        check("ms_pre_bus", bus.out_bus, 32'hA3A2A130);
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        check("ms_serr",  32'(bus.sync_err), 32'h1);
        check("ms_valid", 32'(bus.out_valid), 32'h0);
        check("ms_lock",  32'(bus.locked), 32'h0);
        check("ms_slot",  32'(bus.slot), 32'h0);
        check("ms_bus",   bus.out_bus, 32'hA3A2A130);

        // Reset mid-frame with a beat presented during reset
        drive(1'b1, 1'b1, 8'h11, 1'b0);
        drive(1'b1, 1'b0, 8'h22, 1'b0);
        check("rm_pre_slot", 32'(bus.slot), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h33, 1'b0);
        check("rm_bus",   bus.out_bus, 32'h0);
        check("rm_slot",  32'(bus.slot), 32'h0);
        check("rm_lock",  32'(bus.locked), 32'h0);
        check("rm_valid", 32'(bus.out_valid), 32'h0);
        check("rm_fd",    32'(bus.frame_done), 32'h0);
        check("rm_serr",  32'(bus.sync_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DEMUX_PARITY_EN
        check("par_rst", 32'(bus.parity_err), 32'h0);
        drive(1'b1, 1'b1, 8'h01, 1'b0);
        check("par0_perr", 32'(bus.parity_err), 32'h0);
        drive(1'b1, 1'b0, 8'h02, 1'b0);
        drive(1'b1, 1'b0, 8'h03, 1'b1);
        check("par2_perr",  32'(bus.parity_err), 32'h1);
        check("par2_valid", 32'(bus.out_valid), 32'h0);
        check("par2_slot",  32'(bus.slot), 32'h3);
        check("par2_bus",   bus.out_bus, 32'h00000201);
        drive(1'b1, 1'b0, 8'h04, 1'b1);
        check("par3_perr",  32'(bus.parity_err), 32'h1);
        check("par3_fd",    32'(bus.frame_done), 32'h1);
        check("par3_valid", 32'(bus.out_valid), 32'h0);
        check("par3_bus",   bus.out_bus, 32'h00000201);
        drive(1'b1, 1'b1, 8'h07, 1'b0);
        check("par4_perr",  32'(bus.parity_err), 32'h0);
        check("par4_bus",   bus.out_bus, 32'h00000207);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
